tmem_bus_ctrl: RTL and testbench
================================

TMEM_BUS_CTRL -- requirements
Module: tmem_bus_ctrl

Interface
REQ-001 SHALL have parameter AW, default 20: word-address width, so the array holds 2**AW words of 64-bit data plus 8-bit tag.
REQ-002 SHALL have parameter POP_WORDS, default 2**20: number of populated words; higher addresses are non-existent.
REQ-003 SHALL have parameter RD_LAT, default 1, range 1..15: clocks from read request to data valid.
REQ-004 SHALL have parameter TMO, default 255: idle clocks allowed after the address strobe before a time-out.
REQ-005 SHALL have port clk, in, 1: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, in, 1: synchronous, active-low reset; 0 sampled at a rising edge of clk resets the block.
REQ-007 SHALL have port i_ad, in, 64: address in the strobe cycle, write data otherwise.
REQ-008 SHALL have port i_tag, in, 8: write tag.
REQ-009 SHALL have port i_astb, in, 1: address strobe.
REQ-010 SHALL have port i_atomic, in, 1: read-modify-write flag, sampled with i_astb.
REQ-011 SHALL have port i_rd, in, 1: read request.
REQ-012 SHALL have port i_wr, in, 1: write request.
REQ-013 SHALL have port o_data, out, 64: read data.
REQ-014 SHALL have port o_tag, out, 8: read tag.
REQ-015 SHALL have port o_rdy, out, 1: one-cycle pulse marking read data valid or write done.
REQ-016 SHALL have port o_nxm, out, 1: one-cycle pulse for a non-existent address.
REQ-017 SHALL have port o_tmo, out, 1: one-cycle pulse for a bus time-out.
REQ-018 SHALL have port o_lock, out, 1: high while an atomic lock is held.

Function
REQ-019 SHALL implement FSM states IDLE, ADDR, READ, RESP, LOCK.
REQ-020 In IDLE, i_astb=1 SHALL latch waddr=i_ad[AW-1:0] and atom=i_atomic, clear the time-out counter, and go to ADDR.
REQ-021 In ADDR with i_wr=1 and waddr<POP_WORDS, the block SHALL write {i_ad,i_tag} to mem[waddr] at that edge, then go to RESP.
REQ-022 In ADDR with i_rd=1 and i_wr=0, it SHALL load a counter with RD_LAT-1 and go to READ.
REQ-023 In ADDR, i_rd=1 together with i_wr=1 SHALL be treated as a write; write wins.
REQ-024 In READ, the counter SHALL decrement each clock; at 0, o_data/o_tag SHALL be loaded from mem[waddr] and the FSM SHALL go to RESP.
REQ-025 The total read latency SHALL be RD_LAT clocks from the i_rd edge in ADDR to o_rdy=1 in RESP.
REQ-026 In RESP, o_rdy SHALL be 1 for exactly one clock.
REQ-027 After RESP, the FSM SHALL go to LOCK if atom=1 and the access was a read; otherwise it SHALL go to IDLE.
REQ-028 In LOCK, o_lock SHALL be 1 and i_astb SHALL be ignored.
REQ-029 In LOCK, i_wr=1 SHALL write to the retained waddr without a new strobe, clear the lock, and go to RESP.
REQ-030 In LOCK, i_rd=1 without i_wr SHALL re-read the retained waddr, and the lock SHALL be kept.
REQ-031 When waddr>=POP_WORDS in ADDR or LOCK with i_rd or i_wr, there SHALL be no array access, o_data/o_tag SHALL be 0, o_nxm SHALL pulse instead of o_rdy, any lock SHALL be cleared, and the FSM SHALL go to IDLE.
REQ-032 In ADDR or LOCK, TMO consecutive clocks with i_rd=i_wr=0 SHALL pulse o_tmo, clear the lock, and go to IDLE.
REQ-033 The time-out counter SHALL saturate and SHALL NOT wrap.
REQ-034 i_astb outside IDLE SHALL be ignored and SHALL NOT alter waddr.
REQ-035 o_data/o_tag SHALL hold their last read value until the next read or nxm.
REQ-036 o_rdy, o_nxm and o_tmo SHALL be mutually exclusive in every cycle.
REQ-037 Address arithmetic SHALL use waddr only; i_ad[63:AW] SHALL be ignored in the strobe cycle.

Reset
REQ-038 With reset=0 at a clock edge: state SHALL go to IDLE; o_data=0, o_tag=0, o_rdy=0, o_nxm=0, o_tmo=0, o_lock=0; counters SHALL clear.
REQ-039 Reset during READ or LOCK SHALL abort the access with no later o_rdy.
REQ-040 A write in the same cycle as reset=0 SHALL NOT modify the array.
REQ-041 Array contents SHALL NOT be cleared by reset.

Verification
REQ-042 Write then read: strobe 0x00123, wr {0xDEADBEEF_01234567, tag 0x35}; then strobe 0x00123, rd. Required: o_rdy exactly RD_LAT clocks after rd, o_data=0xDEADBEEF_01234567, o_tag=0x35.
REQ-043 Atomic: strobe 0x00040 with i_atomic=1, rd. Required: o_lock=1 after RESP. A following wr of 0x5 with no strobe writes 0x00040; o_lock=0; a re-read returns 0x5.
REQ-044 Non-existent address: POP_WORDS=0x40000, strobe 0x40000, wr. Required: o_nxm pulse, no o_rdy, the array is unchanged, the FSM is in IDLE.
REQ-045 Time-out: TMO=8, strobe then no rd/wr. Required: o_tmo pulses on the 8th idle clock and the FSM returns to IDLE; a lock held in LOCK is released the same way.
REQ-046 Reset mid-read: RD_LAT=4, reset=0 two clocks after rd. Required: all outputs 0, no o_rdy; a following access works normally.
REQ-047 Simultaneous rd+wr in ADDR: required treated as a write, then o_rdy; a strobe during READ is ignored and waddr is unchanged.

Source files
------------

// File: rtl/tmem_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tmem_bus_ctrl
//
// Word-addressed tagged memory behind a simple strobe/request bus. Each word
// holds 64 bits of data plus an 8-bit tag. Accesses may be plain or atomic.
// An atomic read leaves the word locked, so that a write which follows without
// a new address strobe completes the read-modify-write sequence.
//
// Parameters
//   AW         word-address width (array depth is 2**AW)
//   POP_WORDS  number of populated words; addresses at or above it are
//              non-existent
//   RD_LAT     clocks from the accepted read request to o_rdy (1..15)
//   TMO        idle clocks allowed after the strobe (or while locked) before
//              a time-out (must be >= 1)
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   i_ad       address in the strobe cycle, write data in the write cycle
//   i_tag      write tag
//   i_astb     address strobe (accepted only in IDLE)
//   i_atomic   read-modify-write flag, sampled with i_astb
//   i_rd       read request
//   i_wr       write request (wins over i_rd)
//   o_data     read data (holds until the next read or nxm)
//   o_tag      read tag  (holds until the next read or nxm)
//   o_rdy      one-cycle pulse: read data valid / write done
//   o_nxm      one-cycle pulse: non-existent address
//   o_tmo      one-cycle pulse: bus time-out
//   o_lock     high while an atomic lock is held
//   dbg_state  current FSM state (IDLE=0 ADDR=1 READ=2 RESP=3 LOCK=4)
//
// Bus protocol: the master opens a transaction by pulsing i_astb for one
// clock while the block is idle. It then raises i_rd or i_wr for one clock
// and waits for exactly one of o_rdy, o_nxm or o_tmo, each of which lasts a
// single clock. Once the block has accepted a request it cannot be stalled.
// Request inputs seen while a response is pending are ignored. No strobe is
// needed for the write that follows an atomic read.
// ---------------------------------------------------------------------------
module tmem_bus_ctrl #(
  parameter int AW        = 20,
  parameter int POP_WORDS = 2**20,
  parameter int RD_LAT    = 1,
  parameter int TMO       = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] i_ad,
  input  logic [7:0]  i_tag,
  input  logic        i_astb,
  input  logic        i_atomic,
  input  logic        i_rd,
  input  logic        i_wr,
  output logic [63:0] o_data,
  output logic [7:0]  o_tag,
  output logic        o_rdy,
  output logic        o_nxm,
  output logic        o_tmo,
  output logic        o_lock,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    READ = 3'd2,
    RESP = 3'd3,
    LOCK = 3'd4
  } state_t;

  // The time-out counter only has to reach TMO, so it is sized for that.
  localparam int              TW       = (TMO < 2) ? 1 : $clog2(TMO + 1);
  localparam logic [TW-1:0]   TMO_LAST = TW'(TMO - 1);
  localparam logic [TW-1:0]   TMO_SAT  = TW'(TMO);
  localparam logic [3:0]      RD_LOAD  = 4'(RD_LAT - 1);
  // One extra bit so that POP_WORDS == 2**AW (fully populated) still compares.
  localparam logic [AW:0]     POP_LIM  = (AW + 1)'(POP_WORDS);

  // Storage: {data, tag}. Never reset.
  logic [71:0] mem [0:(2**AW)-1];

  state_t        state;
  state_t        state_nx;

  logic [AW-1:0] waddr;
  logic          atom;
  logic          was_wr;     // last accepted access was a write
  logic          lock;
  logic [TW-1:0] tcnt;
  logic [3:0]    rcnt;

  logic          in_range;
  logic [71:0]   rd_word;

  // Control strobes from the next-state logic.
  logic          latch_addr;
  logic          mem_we;
  logic          mark_wr;
  logic          rd_start;
  logic          rd_dec;
  logic          rd_done;
  logic          set_nxm;
  logic          set_tmo;
  logic          lock_set;
  logic          lock_clr;
  logic          tcnt_clr;
  logic          tcnt_inc;

  assign in_range  = ({1'b0, waddr} < POP_LIM);
  assign rd_word   = mem[waddr];
  assign o_lock    = lock;
  assign dbg_state = state;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and control decode
  // -------------------------------------------------------------------------
  always_comb begin
    state_nx   = state;
    latch_addr = 1'b0;
    mem_we     = 1'b0;
    mark_wr    = 1'b0;
    rd_start   = 1'b0;
    rd_dec     = 1'b0;
    rd_done    = 1'b0;
    set_nxm    = 1'b0;
    set_tmo    = 1'b0;
    lock_set   = 1'b0;
    lock_clr   = 1'b0;
    tcnt_clr   = 1'b0;
    tcnt_inc   = 1'b0;

    unique case (state)
      IDLE: begin
        if (i_astb) begin
          latch_addr = 1'b1;
          tcnt_clr   = 1'b1;
          state_nx   = ADDR;
        end
      end

      // ADDR and LOCK accept the same requests. The only differences are
      // that LOCK uses the address retained from the atomic read, and that
      // a strobe arriving in LOCK has no effect.
      ADDR, LOCK: begin
        if (i_wr || i_rd) begin
          if (!in_range) begin
            set_nxm  = 1'b1;
            lock_clr = 1'b1;
            state_nx = IDLE;
          end else if (i_wr) begin
            mem_we   = 1'b1;
            mark_wr  = 1'b1;
            lock_clr = 1'b1;
            state_nx = RESP;
          end else begin
            rd_start = 1'b1;
            state_nx = READ;
          end
        end else if (tcnt == TMO_LAST) begin
          // This idle clock is the TMO-th one in a row.
          set_tmo  = 1'b1;
          lock_clr = 1'b1;
          state_nx = IDLE;
        end else begin
          tcnt_inc = 1'b1;
        end
      end

      READ: begin
        if (rcnt == 4'd0) begin
          rd_done  = 1'b1;
          state_nx = RESP;
        end else begin
          rd_dec = 1'b1;
        end
      end

      RESP: begin
        // Only a completed atomic read leaves the word locked.
        if (atom && !was_wr) begin
          lock_set = 1'b1;
          tcnt_clr = 1'b1;
          state_nx = LOCK;
        end else begin
          state_nx = IDLE;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Array write port. A write cannot happen while reset is asserted, and the
  // contents survive reset.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset && mem_we) begin
      mem[waddr] <= {i_ad, i_tag};
    end
  end

  // -------------------------------------------------------------------------
  // Datapath and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      waddr  <= '0;
      atom   <= 1'b0;
      was_wr <= 1'b0;
      lock   <= 1'b0;
      tcnt   <= '0;
      rcnt   <= '0;
      o_data <= '0;
      o_tag  <= '0;
      o_rdy  <= 1'b0;
      o_nxm  <= 1'b0;
      o_tmo  <= 1'b0;
    end else begin
      // RESP lasts one clock, so a registered "entering RESP" is a
      // one-cycle pulse. It is aligned with the state itself.
      o_rdy <= (state_nx == RESP);
      o_nxm <= set_nxm;
      o_tmo <= set_tmo;

      // Only the low AW bits of the strobe word form the address.
      if (latch_addr) begin
        waddr <= i_ad[AW-1:0];
        atom  <= i_atomic;
      end

      if (mark_wr) begin
        was_wr <= 1'b1;
      end else if (rd_start) begin
        was_wr <= 1'b0;
      end

      if (lock_clr) begin
        lock <= 1'b0;
      end else if (lock_set) begin
        lock <= 1'b1;
      end

      if (tcnt_clr) begin
        tcnt <= '0;
      end else if (tcnt_inc && (tcnt != TMO_SAT)) begin
        tcnt <= tcnt + 1'b1;
      end

      if (rd_start) begin
        rcnt <= RD_LOAD;
      end else if (rd_dec) begin
        rcnt <= rcnt - 4'd1;
      end

      if (rd_done) begin
        o_data <= rd_word[71:8];
        o_tag  <= rd_word[7:0];
      end else if (set_nxm) begin
        o_data <= '0;
        o_tag  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_tmem_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tmem_bus_ctrl
//
// Self-checking bench for tmem_bus_ctrl. A behavioural model holds the
// expected array contents in an associative array indexed by word address.
// Read results go through an expected queue. All inputs are driven and all
// outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_tmem_bus_ctrl;

  localparam int AW        = 19;
  localparam int POP_WORDS = 'h40000;
  localparam int RD_LAT    = 4;
  localparam int TMO       = 8;
  localparam int WAIT_MAX  = 64;

  logic        clk;
  logic        reset;
  logic [63:0] i_ad;
  logic [7:0]  i_tag;
  logic        i_astb;
  logic        i_atomic;
  logic        i_rd;
  logic        i_wr;
  logic [63:0] o_data;
  logic [7:0]  o_tag;
  logic        o_rdy;
  logic        o_nxm;
  logic        o_tmo;
  logic        o_lock;
  logic [2:0]  dbg_state;

  tmem_bus_ctrl #(
    .AW(AW), .POP_WORDS(POP_WORDS), .RD_LAT(RD_LAT), .TMO(TMO)
  ) dut (
    .clk(clk), .reset(reset), .i_ad(i_ad), .i_tag(i_tag), .i_astb(i_astb),
    .i_atomic(i_atomic), .i_rd(i_rd), .i_wr(i_wr), .o_data(o_data),
    .o_tag(o_tag), .o_rdy(o_rdy), .o_nxm(o_nxm), .o_tmo(o_tmo),
    .o_lock(o_lock), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping / model ----------------
  int          total = 0;
  int          bad   = 0;
  logic [71:0] ref_mem [int];
  logic [71:0] exp_q[$];

  int          resp_k;
  logic        resp_rdy, resp_nxm, resp_tmo, resp_lock;
  logic        after_pulse, after_lock;
  logic [63:0] resp_data;
  logic [7:0]  resp_tag;

  function automatic int mdl_idx(input logic [63:0] a);
    return int'(a[AW-1:0]);
  endfunction

  function automatic bit mdl_exists(input logic [63:0] a);
    return mdl_idx(a) < POP_WORDS;
  endfunction

  task automatic mdl_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] t);
    if (mdl_exists(a)) ref_mem[mdl_idx(a)] = {d, t};
  endtask

  // At most one response pulse may be high in any cycle.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      total++;
      if (int'(o_rdy) + int'(o_nxm) + int'(o_tmo) > 1) begin
        bad++;
        $display("FAIL pulse_exclusive: rdy=%b nxm=%b tmo=%b", o_rdy, o_nxm, o_tmo);
      end
    end
  end

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic strobe(input logic [63:0] a, input logic atomic);
    i_astb = 1'b1; i_ad = a; i_atomic = atomic;
    @(negedge clk);
    i_astb = 1'b0; i_atomic = 1'b0; i_ad = {$urandom, $urandom};
  endtask

  // Waits for a response pulse. resp_k counts the clocks since the request
  // edge. The sample taken one clock later shows whether the pulse lasted
  // exactly one cycle and what the lock looks like after the response.
  task automatic wait_resp();
    int k = 0;
    while (!(o_rdy || o_nxm || o_tmo) && k < WAIT_MAX) begin
      @(negedge clk);
      k++;
    end
    resp_k = k; resp_rdy = o_rdy; resp_nxm = o_nxm; resp_tmo = o_tmo;
    resp_lock = o_lock; resp_data = o_data; resp_tag = o_tag;
    @(negedge clk);
    after_pulse = o_rdy | o_nxm | o_tmo;
    after_lock  = o_lock;
  endtask

  task automatic wr_op(input logic [63:0] d, input logic [7:0] t);
    i_wr = 1'b1; i_ad = d; i_tag = t;
    @(negedge clk);
    i_wr = 1'b0; i_ad = {$urandom, $urandom}; i_tag = 8'($urandom);
    wait_resp();
  endtask

  task automatic rd_op();
    i_rd = 1'b1;
    @(negedge clk);
    i_rd = 1'b0;
    wait_resp();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0; i_ad = '1; i_tag = '1; i_astb = 1'b0; i_atomic = 1'b0;
    i_rd = 1'b0; i_wr = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({o_rdy, o_nxm, o_tmo, o_lock} !== 4'b0 || o_data !== 64'd0 || o_tag !== 8'd0) begin
      bad++;
      $display("FAIL reset_outputs: rdy=%b nxm=%b tmo=%b lock=%b data=%h tag=%h want all 0",
               o_rdy, o_nxm, o_tmo, o_lock, o_data, o_tag);
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({o_rdy, o_nxm, o_tmo, o_lock} !== 4'b0) begin
      bad++;
      $display("FAIL reset_release: rdy=%b nxm=%b tmo=%b lock=%b want 0", o_rdy, o_nxm, o_tmo, o_lock);
    end
  endtask

  task automatic test_write_read();
    strobe(64'h123, 1'b0);
    wr_op(64'hDEADBEEF_01234567, 8'h35);
    mdl_write(64'h123, 64'hDEADBEEF_01234567, 8'h35);
    total++;
    if (resp_rdy !== 1'b1 || resp_k != 0 || after_pulse !== 1'b0) begin
      bad++;
      $display("FAIL wr_done: rdy=%b k=%0d after=%b want rdy=1 k=0 after=0", resp_rdy, resp_k, after_pulse);
    end
    strobe(64'h123, 1'b0);
    rd_op();
    total++;
    if (resp_rdy !== 1'b1 || resp_k != RD_LAT || after_pulse !== 1'b0) begin
      bad++;
      $display("FAIL rd_latency: rdy=%b k=%0d after=%b want rdy=1 k=%0d after=0",
               resp_rdy, resp_k, after_pulse, RD_LAT);
    end
    total++;
    if (resp_data !== 64'hDEADBEEF_01234567 || resp_tag !== 8'h35) begin
      bad++;
      $display("FAIL rd_data: got %h/%h want deadbeef01234567/35", resp_data, resp_tag);
    end
  endtask

  task automatic test_atomic();
    strobe(64'h41, 1'b0); wr_op(64'h1111_2222_3333_4444, 8'h41); mdl_write(64'h41, 64'h1111_2222_3333_4444, 8'h41);
    strobe(64'h40, 1'b0); wr_op(64'hAAAA_0000_0000_0040, 8'h40); mdl_write(64'h40, 64'hAAAA_0000_0000_0040, 8'h40);
    strobe(64'h40, 1'b1);
    rd_op();
    total++;
    if (resp_rdy !== 1'b1 || resp_k != RD_LAT || {resp_data, resp_tag} !== ref_mem[64]) begin
      bad++;
      $display("FAIL atomic_rd: rdy=%b k=%0d data=%h_%h want %h", resp_rdy, resp_k, resp_data, resp_tag, ref_mem[64]);
    end
    total++;
    if (after_lock !== 1'b1) begin
      bad++;
      $display("FAIL lock_set: lock=%b want 1", after_lock);
    end
    // A strobe while locked has no effect; the lock stays held.
    strobe(64'h41, 1'b0);
    total++;
    if (o_lock !== 1'b1) begin
      bad++;
      $display("FAIL lock_ignores_astb: lock=%b want 1", o_lock);
    end
    wr_op(64'h5, 8'h00);
    mdl_write(64'h40, 64'h5, 8'h00);
    total++;
    if (resp_rdy !== 1'b1 || resp_k != 0 || resp_lock !== 1'b0 || after_lock !== 1'b0) begin
      bad++;
      $display("FAIL lock_wr: rdy=%b k=%0d lock=%b/%b want 1,0,0/0", resp_rdy, resp_k, resp_lock, after_lock);
    end
    strobe(64'h41, 1'b0); rd_op();
    total++;
    if ({resp_data, resp_tag} !== ref_mem[65]) begin
      bad++;
      $display("FAIL lock_wr_addr: word 0x41 got %h_%h want %h", resp_data, resp_tag, ref_mem[65]);
    end
    strobe(64'h40, 1'b0); rd_op();
    total++;
    if (resp_data !== 64'h5 || resp_tag !== 8'h00) begin
      bad++;
      $display("FAIL atomic_reread: got %h/%h want 5/00", resp_data, resp_tag);
    end
    // A re-read inside the lock keeps it; idle clocks then time it out.
    strobe(64'h40, 1'b1); rd_op();
    rd_op();
    total++;
    if (resp_rdy !== 1'b1 || resp_k != RD_LAT || resp_data !== 64'h5 || resp_lock !== 1'b1 || after_lock !== 1'b1) begin
      bad++;
      $display("FAIL lock_rd_keep: rdy=%b k=%0d data=%h lock=%b/%b want 1,%0d,5,1/1",
               resp_rdy, resp_k, resp_data, resp_lock, after_lock, RD_LAT);
    end
    wait_resp();
    total++;
    if (resp_tmo !== 1'b1 || resp_rdy !== 1'b0 || resp_k != TMO || resp_lock !== 1'b0) begin
      bad++;
      $display("FAIL lock_tmo: tmo=%b rdy=%b k=%0d lock=%b want 1,0,%0d,0", resp_tmo, resp_rdy, resp_k, resp_lock, TMO);
    end
  endtask

  task automatic test_nxm();
    strobe(64'h0, 1'b0); wr_op(64'h0BAD_F00D_CAFE_0000, 8'h77); mdl_write(64'h0, 64'h0BAD_F00D_CAFE_0000, 8'h77);
    strobe(64'h40000, 1'b0);
    wr_op(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    total++;
    if (resp_nxm !== 1'b1 || resp_rdy !== 1'b0 || resp_k != 0 || after_pulse !== 1'b0) begin
      bad++;
      $display("FAIL nxm_wr: nxm=%b rdy=%b k=%0d after=%b want 1,0,0,0", resp_nxm, resp_rdy, resp_k, after_pulse);
    end
    total++;
    if (resp_data !== 64'd0 || resp_tag !== 8'd0) begin
      bad++;
      $display("FAIL nxm_zero: data=%h tag=%h want 0", resp_data, resp_tag);
    end
    // Back in IDLE: a fresh strobe works and the array is untouched.
    strobe(64'h0, 1'b0); rd_op();
    total++;
    if (resp_rdy !== 1'b1 || {resp_data, resp_tag} !== ref_mem[0]) begin
      bad++;
      $display("FAIL nxm_unchanged: rdy=%b got %h_%h want %h", resp_rdy, resp_data, resp_tag, ref_mem[0]);
    end
    strobe(64'h7FFFF, 1'b0); rd_op();
    total++;
    if (resp_nxm !== 1'b1 || resp_rdy !== 1'b0 || resp_data !== 64'd0 || resp_tag !== 8'd0) begin
      bad++;
      $display("FAIL nxm_rd: nxm=%b rdy=%b data=%h tag=%h want 1,0,0,0", resp_nxm, resp_rdy, resp_data, resp_tag);
    end
  endtask

  task automatic test_timeout();
    strobe(64'h10, 1'b0);
    wait_resp();
    total++;
    if (resp_tmo !== 1'b1 || resp_rdy !== 1'b0 || resp_nxm !== 1'b0 || resp_k != TMO || after_pulse !== 1'b0) begin
      bad++;
      $display("FAIL tmo_addr: tmo=%b rdy=%b nxm=%b k=%0d after=%b want 1,0,0,%0d,0",
               resp_tmo, resp_rdy, resp_nxm, resp_k, after_pulse, TMO);
    end
    // One idle clock short of the limit: the write still completes.
    strobe(64'h10, 1'b0);
    repeat (TMO - 1) @(negedge clk);
    wr_op(64'h1234_5678_9ABC_DEF0, 8'h10);
    mdl_write(64'h10, 64'h1234_5678_9ABC_DEF0, 8'h10);
    total++;
    if (resp_rdy !== 1'b1 || resp_tmo !== 1'b0 || resp_k != 0) begin
      bad++;
      $display("FAIL tmo_edge: rdy=%b tmo=%b k=%0d want 1,0,0", resp_rdy, resp_tmo, resp_k);
    end
  endtask

  task automatic test_rdwr_collision();
    strobe(64'h77, 1'b0);
    i_rd = 1'b1; i_wr = 1'b1; i_ad = 64'hC0DE_0000_0000_0077; i_tag = 8'h7A;
    @(negedge clk);
    i_rd = 1'b0; i_wr = 1'b0;
    wait_resp();
    mdl_write(64'h77, 64'hC0DE_0000_0000_0077, 8'h7A);
    total++;
    if (resp_rdy !== 1'b1 || resp_k != 0) begin
      bad++;
      $display("FAIL rdwr_is_wr: rdy=%b k=%0d want 1,0", resp_rdy, resp_k);
    end
    // A strobe while the read is in flight must not move the address.
    strobe(64'h77, 1'b0);
    exp_q.push_back(ref_mem[119]);
    i_rd = 1'b1;
    @(negedge clk);
    i_rd = 1'b0;
    strobe(64'h78, 1'b0);
    wait_resp();
    total++;
    if (resp_rdy !== 1'b1 || resp_k + 1 != RD_LAT || {resp_data, resp_tag} !== exp_q.pop_front()) begin
      bad++;
      $display("FAIL astb_in_read: rdy=%b k=%0d got %h_%h want %h", resp_rdy, resp_k + 1, resp_data, resp_tag, ref_mem[119]);
    end
  endtask

  task automatic test_reset_mid_read();
    int rdy_seen = 0;
    strobe(64'h55, 1'b0); wr_op(64'h5555_AAAA_5555_AAAA, 8'h55); mdl_write(64'h55, 64'h5555_AAAA_5555_AAAA, 8'h55);
    strobe(64'h55, 1'b0); rd_op();
    strobe(64'h55, 1'b0);
    i_rd = 1'b1;
    @(negedge clk);
    i_rd = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    total++;
    if ({o_rdy, o_nxm, o_tmo, o_lock} !== 4'b0 || o_data !== 64'd0 || o_tag !== 8'd0) begin
      bad++;
      $display("FAIL reset_mid_read: rdy=%b nxm=%b tmo=%b lock=%b data=%h tag=%h want all 0",
               o_rdy, o_nxm, o_tmo, o_lock, o_data, o_tag);
    end
    repeat (2 * RD_LAT + 4) begin
      @(negedge clk);
      if (o_rdy === 1'b1) rdy_seen++;
    end
    total++;
    if (rdy_seen != 0) begin
      bad++;
      $display("FAIL reset_abort: rdy pulses=%0d want 0", rdy_seen);
    end
    strobe(64'h55, 1'b0); rd_op();
    total++;
    if (resp_rdy !== 1'b1 || resp_k != RD_LAT || {resp_data, resp_tag} !== ref_mem[85]) begin
      bad++;
      $display("FAIL after_reset_rd: rdy=%b k=%0d got %h_%h want %h", resp_rdy, resp_k, resp_data, resp_tag, ref_mem[85]);
    end
  endtask

  task automatic test_reset_write();
    strobe(64'h66, 1'b0); wr_op(64'h6666_0000_1111_2222, 8'h66); mdl_write(64'h66, 64'h6666_0000_1111_2222, 8'h66);
    strobe(64'h66, 1'b0);
    i_wr = 1'b1; i_ad = 64'hFFFF_EEEE_DDDD_CCCC; i_tag = 8'hEE; reset = 1'b0;
    @(negedge clk);
    i_wr = 1'b0; reset = 1'b1;
    @(negedge clk);
    strobe(64'h66, 1'b0); rd_op();
    total++;
    if (resp_rdy !== 1'b1 || {resp_data, resp_tag} !== ref_mem[102]) begin
      bad++;
      $display("FAIL reset_blocks_wr: rdy=%b got %h_%h want %h", resp_rdy, resp_data, resp_tag, ref_mem[102]);
    end
  endtask

  task automatic test_random();
    logic [63:0] pool [6];
    logic [63:0] a, d;
    logic [7:0]  t;
    logic [71:0] last_rd, exp;
    int          op;
    for (int i = 0; i < 6; i++) begin
      a = {$urandom, $urandom};
      a[AW-1:0] = AW'($urandom_range(0, POP_WORDS - 1));
      pool[i] = a;
      d = {$urandom, $urandom}; t = 8'($urandom);
      strobe(a, 1'b0); wr_op(d, t); mdl_write(a, d, t);
    end
    // Start from a known output value: a non-existent read zeroes it.
    a = 64'h7FFF0; strobe(a, 1'b0); rd_op();
    last_rd = '0;
    for (int n = 0; n < 30; n++) begin
      op = $urandom_range(0, 9);
      a = {$urandom, $urandom};
      a[AW-1:0] = pool[$urandom_range(0, 5)][AW-1:0];
      if (op < 4) begin
        d = {$urandom, $urandom}; t = 8'($urandom);
        strobe(a, 1'b0); wr_op(d, t); mdl_write(a, d, t);
        total++;
        if (resp_rdy !== 1'b1 || resp_k != 0 || {resp_data, resp_tag} !== last_rd) begin
          bad++;
          $display("FAIL rand_wr[%0d]: rdy=%b k=%0d held=%h_%h want 1,0,%h", n, resp_rdy, resp_k, resp_data, resp_tag, last_rd);
        end
      end else if (op < 8) begin
        exp_q.push_back(ref_mem[mdl_idx(a)]);
        strobe(a, 1'b0); rd_op();
        exp = exp_q.pop_front();
        total++;
        if (resp_rdy !== 1'b1 || resp_k != RD_LAT || {resp_data, resp_tag} !== exp) begin
          bad++;
          $display("FAIL rand_rd[%0d]: addr=%h rdy=%b k=%0d got %h_%h want %h", n, a, resp_rdy, resp_k, resp_data, resp_tag, exp);
        end
        last_rd = exp;
      end else begin
        a[AW-1:0] = AW'($urandom_range(POP_WORDS, (1 << AW) - 1));
        strobe(a, 1'b0);
        if (op == 8) rd_op();
        else wr_op({$urandom, $urandom}, 8'($urandom));
        total++;
        if (resp_nxm !== 1'b1 || resp_rdy !== 1'b0 || resp_data !== 64'd0 || resp_tag !== 8'd0) begin
          bad++;
          $display("FAIL rand_nxm[%0d]: addr=%h nxm=%b rdy=%b data=%h tag=%h want 1,0,0,0",
                   n, a, resp_nxm, resp_rdy, resp_data, resp_tag);
        end
        last_rd = '0;
      end
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    test_reset();
    test_write_read();
    test_atomic();
    test_nxm();
    test_timeout();
    test_rdwr_collision();
    test_reset_mid_read();
    test_reset_write();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
